fetch_unit: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the PC and the IF/ID pipeline register, and talks to a variable-latency instruction memory through a single-outstanding request/response handshake. It sits directly upstream of the hazard detection unit and obeys that unit's PCWrite, IF_ID_Write and IF_ID_Write_Flush controls plus the branch redirect from ID.

---
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, and runs a
// single-outstanding request/response handshake with instruction memory.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        PCWrite,
  input  logic        IF_ID_Write,
  input  logic        IF_ID_Write_Flush,
  input  logic        branchPCSrc,
  input  logic [31:0] BranchTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic        FetchBusy
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HAVE} state_t;

  state_t      state, state_next;
  logic        drop, drop_next;
  logic [31:0] pc_p0, pc_plus4_p0, hold_p0, instr_avail_p0;
  logic        consume, resp_live, avail, take;
  logic [31:0] instr_p1, pc4_p1;
  logic        vld_p1;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  assign pc_plus4_p0    = pc_inc(pc_p0);
  assign consume        = IF_ID_Write & PCWrite & ~branchPCSrc;
  // A response that arrives while Drop is set belongs to a squashed path.
  assign resp_live      = (state == S_WAIT) & IMemReady & ~drop;
  assign avail          = resp_live | (state == S_HAVE);
  assign take           = consume & avail;
  assign instr_avail_p0 = (state == S_HAVE) ? hold_p0 : IMemData;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= S_FETCH;
      drop  <= 1'b0;
    end else begin
      state <= state_next;
      drop  <= drop_next;
    end
  end

  always_comb begin
    state_next = state;
    drop_next  = drop;
    case (state)
      S_FETCH: begin
        if (!branchPCSrc) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (IMemReady) begin
          drop_next = 1'b0;
          if (drop || branchPCSrc) state_next = S_FETCH;
          else if (consume)        state_next = S_WAIT;
          else                     state_next = S_HAVE;
        end else if (branchPCSrc) begin
          drop_next = 1'b1;
        end
      end
      S_HAVE: begin
        if (branchPCSrc)  state_next = S_FETCH;
        else if (consume) state_next = S_WAIT;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Back-to-back issue: consuming an instruction immediately requests PC+4.
  always_comb begin
    IMemReq   = ~Rst & ~branchPCSrc & ((state == S_FETCH) | take);
    IMemAddr  = (state == S_FETCH) ? pc_p0 : pc_plus4_p0;
    FetchBusy = ~Rst & (state == S_WAIT);
  end

  // ---- p0: PC and hold register ----
  always_ff @(posedge Clk) begin
    if (Rst)              pc_p0 <= RESET_PC;
    else if (branchPCSrc) pc_p0 <= BranchTarget;
    else if (take)        pc_p0 <= pc_plus4_p0;
  end

  always_ff @(posedge Clk) begin
    if (resp_live && !consume && !branchPCSrc) hold_p0 <= IMemData;
  end

  // ---- p1: IF/ID register ----
  always_ff @(posedge Clk) begin
    if (Rst || !IF_ID_Write_Flush) begin
      instr_p1 <= NOP;
      pc4_p1   <= 32'd0;
      vld_p1   <= 1'b0;
    end else if (take) begin
      instr_p1 <= instr_avail_p0;
      pc4_p1   <= pc_plus4_p0;
      vld_p1   <= 1'b1;
    end else if (IF_ID_Write) begin
      instr_p1 <= NOP;
      pc4_p1   <= 32'd0;
      vld_p1   <= 1'b0;
    end
  end

  assign IF_ID_Instruction = instr_p1;
  assign IF_ID_PCPlus4     = pc4_p1;
  assign IF_ID_Valid       = vld_p1;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural variable-latency memory plus a
// scoreboard of the instructions expected to land in IF/ID, in order.
module tb_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst, PCWrite, IF_ID_Write, IF_ID_Write_Flush, branchPCSrc;
  logic [31:0] BranchTarget;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_data  = 32'd0;
  logic [31:0] IF_ID_Instruction, IF_ID_PCPlus4;
  logic        IF_ID_Valid, FetchBusy;

  int npass  = 0;
  int ntotal = 0;
  int nfail  = 0;

  typedef struct {
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];

  fetch_unit dut (
    .Clk(Clk), .Rst(Rst), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .IF_ID_Write_Flush(IF_ID_Write_Flush), .branchPCSrc(branchPCSrc),
    .BranchTarget(BranchTarget), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemReady(mem_ready), .IMemData(mem_data),
    .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PCPlus4(IF_ID_PCPlus4),
    .IF_ID_Valid(IF_ID_Valid), .FetchBusy(FetchBusy)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return 32'h2000_0001 + (a >> 2);
  endfunction

  // Memory: one outstanding request, response after `lat` cycles, one-cycle
  // ready pulse. Deliberately not reset so a late response can be produced.
  int          lat = 1;
  int          cnt = 0;
  logic        pend = 1'b0;
  logic [31:0] paddr = 32'd0;

  always @(posedge Clk) begin
    mem_ready <= 1'b0;
    if (pend) begin
      if (cnt <= 1) begin
        mem_ready <= 1'b1;
        mem_data  <= memword(paddr);
        pend      <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
    if (IMemReq) begin
      if (lat <= 1) begin
        mem_ready <= 1'b1;
        mem_data  <= memword(IMemAddr);
      end else begin
        pend  <= 1'b1;
        paddr <= IMemAddr;
        cnt   <= lat - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h (failure %0d)", tag, obs, exp, nfail);
    end
  endtask

  function automatic void push_exp(input logic [31:0] pc4);
    exp_t e;
    e.pc4   = pc4;
    e.instr = memword(pc4 - 32'd4);
    exp_q.push_back(e);
  endfunction

  // One clock; pops the scoreboard whenever IF/ID loaded a valid instruction.
  task automatic cyc();
    logic wr;
    exp_t e;
    wr = IF_ID_Write & IF_ID_Write_Flush & ~Rst;
    @(posedge Clk);
    #1;
    if (wr && IF_ID_Valid === 1'b1) begin
      check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_pc4", IF_ID_PCPlus4, e.pc4);
        check("sb_instr", IF_ID_Instruction, e.instr);
      end
    end
  endtask

  task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
    #1;
    check({tag, "_req"}, 32'(IMemReq), 32'(req));
    if (req) check({tag, "_addr"}, IMemAddr, addr);
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_vld"}, 32'(IF_ID_Valid), 32'd0);
    check({tag, "_instr"}, IF_ID_Instruction, 32'd0);
    check({tag, "_pc4"}, IF_ID_PCPlus4, 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit %0d", $time, 50000);
    $fatal(1, "watchdog expired");
  end

  initial begin
    Rst = 1'b1; PCWrite = 1'b1; IF_ID_Write = 1'b1; IF_ID_Write_Flush = 1'b1;
    branchPCSrc = 1'b0; BranchTarget = 32'd0;

    // Reset
    repeat (2) begin
      #1;
      check("rst_req", 32'(IMemReq), 32'd0);
      check("rst_busy", 32'(FetchBusy), 32'd0);
      cyc();
    end
    check_bubble("rst");

    // No stalls, 1-cycle memory: one instruction per cycle
    Rst = 1'b0;
    for (int k = 2; k <= 8; k++) push_exp(32'(4 * (k - 1)));
    for (int k = 1; k <= 8; k++) begin
      check_req("p1", 1'b1, 32'(4 * (k - 1)));
      cyc();
      if (k >= 2) begin
        check("p1_vld", 32'(IF_ID_Valid), 32'd1);
        check("p1_pc4", IF_ID_PCPlus4, 32'(4 * (k - 1)));
      end
    end

    // Two-cycle stall while a response arrives
    PCWrite = 1'b0; IF_ID_Write = 1'b0;
    repeat (2) begin
      check_req("p2_stall", 1'b0, 32'd0);
      cyc();
      check("p2_busy", 32'(FetchBusy), 32'd0);
      check("p2_hold_pc4", IF_ID_PCPlus4, 32'd28);
      check("p2_hold_vld", 32'(IF_ID_Valid), 32'd1);
    end
    PCWrite = 1'b1; IF_ID_Write = 1'b1;
    push_exp(32'd32);
    check_req("p2_rel", 1'b1, 32'd32);
    cyc();
    check("p2_rel_pc4", IF_ID_PCPlus4, 32'd32);

    // 3-cycle memory: bubbles between instructions
    lat = 3;
    for (int j = 0; j < 3; j++) push_exp(32'(36 + 4 * j));
    for (int j = 0; j < 3; j++) begin
      check_req("p3", 1'b1, 32'(36 + 4 * j));
      cyc();
      check("p3_pc4", IF_ID_PCPlus4, 32'(36 + 4 * j));
      if (j < 2) begin
        repeat (2) begin
          check_req("p3_wait", 1'b0, 32'd0);
          check("p3_busy", 32'(FetchBusy), 32'd1);
          cyc();
          check_bubble("p3_bubble");
        end
      end
    end

    // Redirect + flush while a request is outstanding
    branchPCSrc = 1'b1; BranchTarget = 32'h0000_0040; IF_ID_Write_Flush = 1'b0;
    check_req("p4_br", 1'b0, 32'd0);
    cyc();
    check_bubble("p4_flush");
    check("p4_drop_busy", 32'(FetchBusy), 32'd1);
    branchPCSrc = 1'b0; IF_ID_Write_Flush = 1'b1;
    check_req("p4_drop_wait", 1'b0, 32'd0);
    cyc();
    lat = 1;
    check_req("p4_stale", 1'b0, 32'd0);
    cyc();
    check("p4_fetch_busy", 32'(FetchBusy), 32'd0);
    check_bubble("p4_stale");
    push_exp(32'h0000_0044);
    check_req("p4_tgt", 1'b1, 32'h0000_0040);
    cyc();
    check_req("p4_next", 1'b1, 32'h0000_0044);
    cyc();
    check("p4_pc4", IF_ID_PCPlus4, 32'h0000_0044);

    // PC wrap at 32'hFFFF_FFFC (redirect while a live response arrives)
    branchPCSrc = 1'b1; BranchTarget = 32'hFFFF_FFFC;
    check_req("p5_br", 1'b0, 32'd0);
    cyc();
    check_bubble("p5_br");
    branchPCSrc = 1'b0;
    check_req("p5_top", 1'b1, 32'hFFFF_FFFC);
    cyc();
    push_exp(32'd0);
    push_exp(32'd4);
    check_req("p5_wrap", 1'b1, 32'd0);
    cyc();
    check("p5_wrap_pc4", IF_ID_PCPlus4, 32'd0);
    check("p5_wrap_vld", 32'(IF_ID_Valid), 32'd1);
    lat = 2;
    check_req("p5_after", 1'b1, 32'd4);
    cyc();

    // Reset mid-WAIT with the response due the following cycle
    Rst = 1'b1;
    check_req("p6_rst", 1'b0, 32'd0);
    check("p6_rst_busy", 32'(FetchBusy), 32'd0);
    cyc();
    check_bubble("p6_rst");
    Rst = 1'b0; lat = 1;
    for (int k = 1; k <= 3; k++) push_exp(32'(4 * k));
    check_req("p6_restart", 1'b1, 32'd0);
    check("p6_restart_busy", 32'(FetchBusy), 32'd0);
    cyc();
    check_bubble("p6_late");
    for (int k = 1; k <= 3; k++) begin
      check_req("p6_run", 1'b1, 32'(4 * k));
      cyc();
      check("p6_pc4", IF_ID_PCPlus4, 32'(4 * k));
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
